alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle RV32 ALU. Executes RISC-V integer ALU, set-less-than and branch-compare operations on XLEN-bit operands behind a valid/ready interface. Shifts run iteratively, SHIFT_STEP bits per cycle, under a small FSM. Sits between operand read and writeback/branch resolution, and also produces the JALR target and an optional taken-branch counter.

---
 rtl/alu_pipe.sv | 197 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked RV32-style integer ALU with an iterative shifter.
//
// Ports:
//   clock, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready depends only on state and out_ready)
//   op, a, b              operation code and operands (shift amount = b[log2(XLEN)-1:0])
//   out_valid / out_ready result handshake
//   result, taken, jlr    registered result, branch condition, (a+b) & ~1
//   br_count              saturating count of accepted taken branches
//
// Build option: define ALU_BRANCH_COUNT_EN to include the taken-branch counter;
// when undefined, br_count is tied to zero.
module alu_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             taken,
  output logic [XLEN-1:0]  jlr,
  output logic [CNT_W-1:0] br_count
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8,  OP_SLTU = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11;
  localparam logic [3:0] OP_BLT = 4'd12, OP_BGE  = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15;

  localparam logic [SHW:0] STEP_W = SHIFT_STEP[SHW:0];

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] jlr_q, jlr_d;
  logic [XLEN-1:0] sh_q, sh_d;
  logic [SHW:0]    rem_q, rem_d;
  logic [1:0]      sh_op_q, sh_op_d;

  logic            accept;
  logic [XLEN-1:0] sum;
  logic [XLEN:0]   diff_u;
  logic            lt_u, lt_s, eq;
  logic [XLEN-1:0] alu_res;
  logic            alu_taken;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic [SHW:0]    step_amt;
  logic [SHW:0]    rem_next;
  logic [XLEN-1:0] sh_next;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign out_valid = (state_q == S_HOLD);
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign taken     = taken_q;
  assign jlr       = jlr_q;

  assign sum    = a + b;
  assign diff_u = {1'b0, a} - {1'b0, b};
  assign lt_u   = diff_u[XLEN];
  // Signed order equals unsigned order with both sign bits flipped, so the
  // single zero-extended borrow serves both compares.
  assign lt_s   = diff_u[XLEN] ^ a[XLEN-1] ^ b[XLEN-1];
  assign eq     = (a == b);

  assign shamt    = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  always_comb begin
    alu_res   = a;
    alu_taken = 1'b0;
    case (op)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff_u[XLEN-1:0];
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_BEQ:  alu_taken = eq;
      OP_BNE:  alu_taken = !eq;
      OP_BLT:  alu_taken = lt_s;
      OP_BGE:  alu_taken = !lt_s;
      OP_BLTU: alu_taken = lt_u;
      OP_BGEU: alu_taken = !lt_u;
      default: ;  // shifts reach here only with a zero amount: pass a through
    endcase
    if (op >= OP_BEQ) alu_res = {{(XLEN-1){1'b0}}, alu_taken};
  end

  // One shifter step: min(SHIFT_STEP, remaining) bits.
  always_comb begin
    step_amt = (rem_q >= STEP_W) ? STEP_W : rem_q;
    rem_next = rem_q - step_amt;
    case (sh_op_q)
      2'b01:   sh_next = sh_q << step_amt;
      2'b10:   sh_next = sh_q >> step_amt;
      default: sh_next = $signed(sh_q) >>> step_amt;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    taken_d  = taken_q;
    jlr_d    = jlr_q;
    sh_d     = sh_q;
    rem_d    = rem_q;
    sh_op_d  = sh_op_q;
    case (state_q)
      S_IDLE: ;
      S_SHIFT: begin
        sh_d  = sh_next;
        rem_d = rem_next;
        if (rem_next == '0) begin
          result_d = sh_next;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: if (out_ready && !in_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Accept is shared by IDLE and HOLD; in HOLD it also retires the current result.
    if (accept) begin
      jlr_d = sum & {{(XLEN-1){1'b1}}, 1'b0};
      if (is_shift && (shamt != '0)) begin
        sh_d    = a;
        rem_d   = {1'b0, shamt};
        sh_op_d = op[1:0];
        taken_d = 1'b0;
        state_d = S_SHIFT;
      end else begin
        result_d = alu_res;
        taken_d  = alu_taken;
        state_d  = S_HOLD;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      taken_q  <= 1'b0;
      jlr_q    <= '0;
      sh_q     <= '0;
      rem_q    <= '0;
      sh_op_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      taken_q  <= taken_d;
      jlr_q    <= jlr_d;
      sh_q     <= sh_d;
      rem_q    <= rem_d;
      sh_op_q  <= sh_op_d;
    end
  end

`ifdef ALU_BRANCH_COUNT_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic             is_branch;

  assign is_branch = (op >= OP_BEQ);

  always_comb begin
    br_cnt_d = br_cnt_q;
    if (accept && is_branch && alu_taken && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) br_cnt_q <= '0;
    else        br_cnt_q <= br_cnt_d;
  end

  assign br_count = br_cnt_q;
`else
  assign br_count = '0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STEP = 8;
  localparam int unsigned CW   = 2;
`ifdef ALU_BRANCH_COUNT_EN
  localparam int unsigned BR_EN = 1;
`else
  localparam int unsigned BR_EN = 0;
`endif
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      op = '0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            taken;
  logic [XLEN-1:0] jlr;
  logic [CW-1:0]   br_count;

  always #5 clock = ~clock;

  alu_pipe #(.XLEN(XLEN), .SHIFT_STEP(STEP), .CNT_W(CW)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .taken(taken), .jlr(jlr), .br_count(br_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  bit          rnd_rdy  = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [XLEN-1:0] r;
    logic            t;
    logic [XLEN-1:0] j;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int unsigned model_cnt = 0;

  // Reference semantics straight from the ISA definitions.
  function automatic void ref_alu(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                                  output logic [XLEN-1:0] r, output logic t);
    int sh;
    sh = int'(y[4:0]);
    t  = 1'b0;
    r  = '0;
    case (o)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = x << sh;
      4'd6:  r = x >> sh;
      4'd7:  r = $signed(x) >>> sh;
      4'd8:  r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'd9:  r = (x < y) ? 1 : 0;
      4'd10: t = (x == y);
      4'd11: t = (x != y);
      4'd12: t = ($signed(x) < $signed(y));
      4'd13: t = ($signed(x) >= $signed(y));
      4'd14: t = (x < y);
      default: t = (x >= y);
    endcase
    if (o >= 4'd10) r = t ? 1 : 0;
  endfunction

  logic            prev_stall = 1'b0;
  logic [XLEN-1:0] prev_res = '0;
  logic [XLEN-1:0] m_r;
  logic            m_t;

  always @(negedge clock) begin
    if (!rst_n) begin
      expq.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      check("br_count", 64'(br_count), 64'(model_cnt));
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_result", 64'(result), 64'(prev_res));
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("spurious_out", 64'd1, 64'd0);
        else begin
          mon_e = expq.pop_front();
          check("result", 64'(result), 64'(mon_e.r));
          check("taken", 64'(taken), 64'(mon_e.t));
          check("jlr", 64'(jlr), 64'(mon_e.j));
        end
      end
      if (in_valid && in_ready) begin
        ref_alu(op, a, b, m_r, m_t);
        mon_e.r = m_r;
        mon_e.t = m_t;
        mon_e.j = (a + b) & ~32'd1;
        expq.push_back(mon_e);
        if (BR_EN != 0 && op >= 4'd10 && m_t && model_cnt < CNT_MAX) model_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    bit done;
    done     = 1'b0;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      done = in_ready;
      @(posedge clock);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (expq.size() == 0) break;
    end
    check("drain", 64'(expq.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned     n;
    int unsigned     c0;
    logic [XLEN-1:0] corner [5];
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;

    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    corner[4] = 32'h0000_0001;

    repeat (3) @(posedge clock);
    #1 rst_n = 1'b1;
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_taken", 64'(taken), 64'd0);
    check("rst_jlr", 64'(jlr), 64'd0);
    check("rst_br_count", 64'(br_count), 64'd0);
    tick();

    // ADD overflow wraps; result visible right after the accept edge.
    send(4'd0, 32'h7FFF_FFFF, 32'd1);
    @(negedge clock);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'h8000_0000);
    check("add_jlr", 64'(jlr), 64'h8000_0000);
    check("add_taken", 64'(taken), 64'd0);
    tick();
    drain();

    // SRA by 31: multi-step shift, in_ready low while busy.
    send(4'd7, 32'h8000_0000, 32'd31);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (out_valid) break;
      check("shift_in_ready", 64'(in_ready), 64'd0);
      n++;
    end
    check("sra_latency", 64'(n + 1), 64'((31 + STEP - 1) / STEP + 1));
    check("sra_result", 64'(result), 64'hFFFF_FFFF);
    tick();
    drain();

    // Signed vs unsigned branch compare on the same operands.
    do_reset();
    send(4'd12, 32'hFFFF_FFFF, 32'd1);
    @(negedge clock);
    check("blt_taken", 64'(taken), 64'd1);
    check("blt_result", 64'(result), 64'd1);
    tick();
    send(4'd14, 32'hFFFF_FFFF, 32'd1);
    @(negedge clock);
    check("bltu_taken", 64'(taken), 64'd0);
    check("bltu_result", 64'(result), 64'd0);
    tick();
    drain();
    check("br_count_one", 64'(br_count), 64'(BR_EN));

    // Back-pressure: second ADD waits, first result held.
    out_ready = 1'b0;
    send(4'd0, 32'd1, 32'd2);
    fork
      send(4'd0, 32'd3, 32'd4);
      begin
        repeat (3) begin
          @(negedge clock);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    c0 = cyc;
    for (int i = 0; i < 5; i++) send(4'd0, $urandom, $urandom);
    check("throughput", 64'(cyc - c0), 64'd5);
    drain();

    // Reset in the middle of a shift discards it.
    send(4'd5, 32'h1234_5678, 32'd20);
    @(negedge clock);
    check("sll_busy", 64'(out_valid), 64'd0);
    tick();
    do_reset();
    @(negedge clock);
    check("rst_shift_valid", 64'(out_valid), 64'd0);
    check("rst_shift_ready", 64'(in_ready), 64'd1);
    check("rst_shift_result", 64'(result), 64'd0);
    repeat (6) begin
      @(negedge clock);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    tick();

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 5; i++) send(4'd10, 32'd7, 32'd7);
    drain();
    check("br_sat", 64'(br_count), 64'(BR_EN * CNT_MAX));

    // Randomised traffic with random back-pressure and idle gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 5) == 0) rb = ra;
      send(4'($urandom_range(0, 15)), ra, rb);
    end
    rnd_rdy = 1'b0;
    drain();
    check("final_queue", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
